// File: rtl/graphics_pkg.sv
// Shared motion types and constants for the player sprite.
// Jump items are built only when PLAYER_JUMP_EN is defined.
package graphics_pkg;

`ifdef PLAYER_JUMP_EN
   typedef enum logic [1:0] {
      IDLE,
      WALK_L,
      WALK_R,
      JUMP
   } motion_state_t;
`else
   typedef enum logic [1:0] {
      IDLE,
      WALK_L,
      WALK_R
   } motion_state_t;
`endif

   localparam logic [3:0] ANIM_IDLE       = 4'd0;
   localparam logic [3:0] ANIM_WALK_FIRST = 4'd1;
   localparam logic [3:0] ANIM_WALK_LAST  = 4'd4;
`ifdef PLAYER_JUMP_EN
   localparam logic [3:0] ANIM_JUMP       = 4'd5;
`endif

   localparam logic signed [7:0] JUMP_V0 = -8'sd12;
   localparam logic signed [7:0] GRAVITY = 8'sd1;

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronizes VGA_VS and emits a one-cycle tick per falling edge.
// The tick is registered so outputs update four clocks after the fall.
module frame_tick_gen (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_vs,
   output logic o_tick
);

   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic r_tick;

   // two-flop synchronizer, history flop and registered fall detect
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_s3   <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_s1   <= i_vs;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_tick <= r_s3 & ~r_s2;
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/player_motion_ctrl.sv
// Player position, facing and animation, updated once per VGA frame.
// Define PLAYER_JUMP_EN to build the JUMP state and vertical velocity.
module player_motion_ctrl
   import graphics_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SPRITE_W = 53,
   parameter int START_X  = 200,
   parameter int GROUND_Y = 400,
   parameter int STEP     = 5,
   parameter int ANIM_DIV = 6
) (
   input  logic       CLK_50,
   input  logic       RESET_N,
   input  logic       VGA_VS,
   input  logic       left,
   input  logic       right,
   input  logic       jump,
   output logic [9:0] p_X,
   output logic [9:0] p_Y,
   output logic [3:0] p_animation,
   output logic       facing_left,
   output logic       frame_tick
);

   localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - SPRITE_W);
   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic [3:0]         DIV_N  = 4'(ANIM_DIV);

   logic                 w_tick;
   logic                 w_lo;
   logic                 w_ro;
   logic signed [10:0]   w_xl;
   logic signed [10:0]   w_xr;
   logic [9:0]           w_x_nx;
   motion_state_t        w_st_nx;
   logic [3:0]           w_div_inc;
   logic [3:0]           w_anim_nx;
   logic [3:0]           w_div_nx;

   logic [9:0]           r_x;
   logic [3:0]           r_anim;
   logic [3:0]           r_div;
   logic                 r_face;
   logic                 r_ftick;
   motion_state_t        r_state;

   frame_tick_gen u_tick (
      .i_clk   (CLK_50),
      .i_rst_n (RESET_N),
      .i_vs    (VGA_VS),
      .o_tick  (w_tick)
   );

   assign w_lo = left & ~right;
   assign w_ro = right & ~left;
   assign w_xl = $signed({1'b0, r_x}) - STEP_S;
   assign w_xr = $signed({1'b0, r_x}) + STEP_S;
   assign w_div_inc = r_div + 4'd1;

   // clamped X and walk state chosen by this frame's controls
   always_comb begin
      w_x_nx  = r_x;
      w_st_nx = IDLE;
      if (w_lo) begin
         w_st_nx = WALK_L;
         w_x_nx  = (w_xl < 0) ? 10'd0 : w_xl[9:0];
      end else if (w_ro) begin
         w_st_nx = WALK_R;
         w_x_nx  = (w_xr > X_MAX) ? X_MAX[9:0] : w_xr[9:0];
      end
   end

   // walk animation: restart on entry, advance every DIV_N frames
   always_comb begin
      w_anim_nx = ANIM_IDLE;
      w_div_nx  = 4'd0;
      if (w_st_nx != IDLE) begin
         if (w_st_nx == r_state) begin
            if (w_div_inc == DIV_N) begin
               w_anim_nx = (r_anim == ANIM_WALK_LAST) ?
                           ANIM_WALK_FIRST : r_anim + 4'd1;
            end else begin
               w_anim_nx = r_anim;
               w_div_nx  = w_div_inc;
            end
         end else begin
            w_anim_nx = ANIM_WALK_FIRST;
         end
      end
   end

`ifdef PLAYER_JUMP_EN
   localparam logic signed [11:0] Y_GND = 12'(GROUND_Y);
   logic signed [7:0]  r_vy;
   logic [9:0]         r_y;
   logic signed [11:0] w_y_sum;
   assign w_y_sum = $signed({2'b00, r_y}) +
                    $signed({{4{r_vy[7]}}, r_vy});
   assign p_Y = r_y;
`else
   logic w_unused_jump;
   assign w_unused_jump = jump;
   assign p_Y = 10'(GROUND_Y);
`endif

   // motion state machine; all state moves only on a frame tick
   always_ff @(posedge CLK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_x     <= 10'(START_X);
         r_anim  <= ANIM_IDLE;
         r_div   <= 4'd0;
         r_face  <= 1'b0;
         r_ftick <= 1'b0;
         r_state <= IDLE;
`ifdef PLAYER_JUMP_EN
         r_vy    <= 8'sd0;
         r_y     <= 10'(GROUND_Y);
`endif
      end else begin
         r_ftick <= w_tick;
         if (w_tick) begin
            r_x <= w_x_nx;
            if (w_lo) begin
               r_face <= 1'b1;
            end else if (w_ro) begin
               r_face <= 1'b0;
            end
`ifdef PLAYER_JUMP_EN
            if (r_state == JUMP) begin
               if (w_y_sum >= Y_GND) begin
                  r_y     <= 10'(GROUND_Y);
                  r_vy    <= 8'sd0;
                  r_state <= w_st_nx;
                  r_anim  <= w_anim_nx;
                  r_div   <= w_div_nx;
               end else begin
                  r_y    <= w_y_sum[9:0];
                  r_vy   <= r_vy + GRAVITY;
                  r_anim <= ANIM_JUMP;
               end
            end else if (jump) begin
               r_state <= JUMP;
               r_vy    <= JUMP_V0;
               r_anim  <= ANIM_JUMP;
               r_div   <= 4'd0;
            end else
`endif
            begin
               r_state <= w_st_nx;
               r_anim  <= w_anim_nx;
               r_div   <= w_div_nx;
            end
         end
      end
   end

   assign p_X         = r_x;
   assign p_animation = r_anim;
   assign facing_left = r_face;
   assign frame_tick  = r_ftick;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Randomized self-checking bench for player_motion_ctrl.
// Reference model: clamped integer motion and frame-count animation.
module tb_player_motion_ctrl;

   localparam int SCREEN_W = 640;
   localparam int SPRITE_W = 53;
   localparam int START_X  = 200;
   localparam int GROUND_Y = 400;
   localparam int STEP     = 5;
   localparam int ANIM_DIV = 6;
   localparam int XMAX     = SCREEN_W - SPRITE_W;

   logic       CLK_50  = 1'b0;
   logic       RESET_N = 1'b0;
   logic       VGA_VS  = 1'b1;
   logic       left    = 1'b0;
   logic       right   = 1'b0;
   logic       jump    = 1'b0;
   logic [9:0] p_X;
   logic [9:0] p_Y;
   logic [3:0] p_animation;
   logic       facing_left;
   logic       frame_tick;

   int checks   = 0;
   int failures = 0;

   // model state: x, facing, direction (-1/0/+1), frames since walk entry
   int  m_x;
   bit  m_face;
   int  m_dir;
   int  m_n;
   int  m_anim;

   player_motion_ctrl #(
      .SCREEN_W (SCREEN_W),
      .SPRITE_W (SPRITE_W),
      .START_X  (START_X),
      .GROUND_Y (GROUND_Y),
      .STEP     (STEP),
      .ANIM_DIV (ANIM_DIV)
   ) dut (
      .CLK_50      (CLK_50),
      .RESET_N     (RESET_N),
      .VGA_VS      (VGA_VS),
      .left        (left),
      .right       (right),
      .jump        (jump),
      .p_X         (p_X),
      .p_Y         (p_Y),
      .p_animation (p_animation),
      .facing_left (facing_left),
      .frame_tick  (frame_tick)
   );

   always #10 CLK_50 = ~CLK_50;

   function automatic void model_reset();
      m_x    = START_X;
      m_face = 1'b0;
      m_dir  = 0;
      m_n    = 0;
      m_anim = 0;
   endfunction

   function automatic void model_step(input bit l, input bit r);
      int d;
      d = (l && !r) ? -1 : (r && !l) ? 1 : 0;
      if (d == 0) begin
         m_dir  = 0;
         m_anim = 0;
      end else begin
         m_n    = (d != m_dir) ? 0 : m_n + 1;
         m_dir  = d;
         m_anim = 1 + (m_n / ANIM_DIV) % 4;
         m_x    = m_x + d * STEP;
         if (m_x < 0) m_x = 0;
         if (m_x > XMAX) m_x = XMAX;
         m_face = (d < 0);
      end
   endfunction

   // one VGA_VS pulse; reports tick latency and pulse width.
   // Controls are scrambled while VS is high to show they are ignored.
   task automatic do_tick(input bit l, input bit r,
                          output int lat, output int wid);
      @(negedge CLK_50);
      left   = l;
      right  = r;
      VGA_VS = 1'b0;
      lat    = -1;
      wid    = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK_50);
         if (frame_tick) begin
            wid++;
            if (lat < 0) lat = i;
         end
      end
      VGA_VS = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK_50);
         left  = 1'($urandom);
         right = 1'($urandom);
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      VGA_VS  = 1'b1;
      repeat (3) @(negedge CLK_50);
      checks++;
      if (p_X !== 10'(START_X) || p_Y !== 10'(GROUND_Y) ||
          p_animation !== 4'd0 || facing_left !== 1'b0 ||
          frame_tick !== 1'b0) begin
         failures++;
         $display("FAIL reset: X=%0d Y=%0d anim=%0d face=%0b ft=%0b",
                  p_X, p_Y, p_animation, facing_left, frame_tick);
      end
      RESET_N = 1'b1;
      repeat (5) @(negedge CLK_50);
      model_reset();
   endtask

   task automatic test_walk_right();
      int lat, wid, pulses;
      pulses = 0;
      for (int k = 1; k <= 3; k++) begin
         do_tick(1'b0, 1'b1, lat, wid);
         model_step(1'b0, 1'b1);
         pulses += wid;
         checks++;
         if (lat !== 4) begin
            failures++;
            $display("FAIL latency: got %0d want 4", lat);
         end
         checks++;
         if (p_X !== 10'(START_X + 5 * k) || p_animation !== 4'd1 ||
             facing_left !== 1'b0) begin
            failures++;
            $display("FAIL walk_right%0d: X=%0d anim=%0d face=%0b want %0d 1 0",
                     k, p_X, p_animation, facing_left, START_X + 5 * k);
         end
      end
      checks++;
      if (pulses !== 3) begin
         failures++;
         $display("FAIL tick_pulses: got %0d want 3", pulses);
      end
   endtask

   task automatic test_both();
      int lat, wid;
      int x0;
      bit f0;
      x0 = m_x;
      f0 = m_face;
      for (int k = 0; k < 5; k++) begin
         do_tick(1'b1, 1'b1, lat, wid);
         model_step(1'b1, 1'b1);
         checks++;
         if (p_X !== 10'(x0) || p_animation !== 4'd0 ||
             facing_left !== f0) begin
            failures++;
            $display("FAIL both: X=%0d anim=%0d face=%0b want %0d 0 %0b",
                     p_X, p_animation, facing_left, x0, f0);
         end
      end
   endtask

   task automatic test_anim();
      int lat, wid, want;
      for (int k = 1; k <= 13; k++) begin
         do_tick(1'b0, 1'b1, lat, wid);
         model_step(1'b0, 1'b1);
         want = (k <= 6) ? 1 : (k <= 12) ? 2 : 3;
         checks++;
         if (p_animation !== 4'(want) || p_X !== 10'(m_x)) begin
            failures++;
            $display("FAIL anim%0d: anim=%0d X=%0d want %0d %0d",
                     k, p_animation, p_X, want, m_x);
         end
      end
      do_tick(1'b1, 1'b0, lat, wid);
      model_step(1'b1, 1'b0);
      checks++;
      if (p_animation !== 4'd1 || facing_left !== 1'b1 ||
          p_X !== 10'(m_x)) begin
         failures++;
         $display("FAIL reverse: anim=%0d face=%0b X=%0d want 1 1 %0d",
                  p_animation, facing_left, p_X, m_x);
      end
   endtask

   task automatic test_clamp(input bit go_left);
      int lat, wid, edge_x;
      edge_x = go_left ? 0 : XMAX;
      for (int k = 0; k < 130; k++) begin
         do_tick(go_left, !go_left, lat, wid);
         model_step(go_left, !go_left);
         checks++;
         if (p_X !== 10'(m_x) || p_animation !== 4'(m_anim) ||
             facing_left !== m_face) begin
            failures++;
            $display("FAIL clamp%0d: X=%0d anim=%0d face=%0b want %0d %0d %0b",
                     k, p_X, p_animation, facing_left, m_x, m_anim, m_face);
         end
      end
      checks++;
      if (p_X !== 10'(edge_x)) begin
         failures++;
         $display("FAIL clamp_edge: X=%0d want %0d", p_X, edge_x);
      end
   endtask

   task automatic test_random();
      int lat, wid;
      bit l, r;
      for (int k = 0; k < 80; k++) begin
         l = 1'($urandom);
         r = 1'($urandom);
         if ($urandom_range(3) != 0) begin
            l = (k / 10) % 2 == 0;
            r = !l;
         end
         do_tick(l, r, lat, wid);
         model_step(l, r);
         checks++;
         if (lat !== 4 || wid !== 1 || p_X !== 10'(m_x) ||
             p_animation !== 4'(m_anim) || facing_left !== m_face ||
             p_Y !== 10'(GROUND_Y)) begin
            failures++;
            $display("FAIL random%0d: lat=%0d w=%0d X=%0d a=%0d f=%0b Y=%0d want X=%0d a=%0d f=%0b",
                     k, lat, wid, p_X, p_animation, facing_left, p_Y,
                     m_x, m_anim, m_face);
         end
      end
   endtask

   task automatic test_async_reset();
      int lat, wid, seen;
      do_tick(1'b1, 1'b0, lat, wid);
      model_step(1'b1, 1'b0);
      @(negedge CLK_50);
      VGA_VS = 1'b0;
      @(posedge CLK_50);
      #3;
      RESET_N = 1'b0;
      #1;
      checks++;
      if (p_X !== 10'(START_X) || p_Y !== 10'(GROUND_Y) ||
          p_animation !== 4'd0 || facing_left !== 1'b0 ||
          frame_tick !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: X=%0d Y=%0d anim=%0d face=%0b ft=%0b",
                  p_X, p_Y, p_animation, facing_left, frame_tick);
      end
      repeat (3) @(negedge CLK_50);
      RESET_N = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK_50);
         if (frame_tick) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL stale_tick: got %0d pulses want 0", seen);
      end
      VGA_VS = 1'b1;
      repeat (5) @(negedge CLK_50);
      model_reset();
      do_tick(1'b0, 1'b1, lat, wid);
      model_step(1'b0, 1'b1);
      checks++;
      if (lat !== 4 || p_X !== 10'(m_x) || p_animation !== 4'd1) begin
         failures++;
         $display("FAIL post_reset: lat=%0d X=%0d anim=%0d want 4 %0d 1",
                  lat, p_X, p_animation, m_x);
      end
   endtask

`ifdef PLAYER_JUMP_EN
   task automatic test_jump();
      int lat, wid, y, vy, peak, k;
      bit landed;
      jump = 1'b1;
      do_tick(1'b0, 1'b0, lat, wid);
      jump = 1'b0;
      y = GROUND_Y;
      vy = -12;
      peak = y;
      landed = 1'b0;
      k = 0;
      while (!landed && k < 40) begin
         do_tick(1'b0, 1'b0, lat, wid);
         k++;
         if (y + vy >= GROUND_Y) begin
            y = GROUND_Y;
            landed = 1'b1;
         end else begin
            y = y + vy;
            vy = vy + 1;
         end
         if (y < peak) peak = y;
         checks++;
         if (p_Y !== 10'(y) ||
             p_animation !== (landed ? 4'd0 : 4'd5)) begin
            failures++;
            $display("FAIL jump%0d: Y=%0d anim=%0d want %0d", k,
                     p_Y, p_animation, y);
         end
      end
      checks++;
      if (!landed || peak != 322) begin
         failures++;
         $display("FAIL jump_arc: landed=%0b peak=%0d want 1 322",
                  landed, peak);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_walk_right();
      test_both();
      test_anim();
      test_clamp(1'b1);
      test_clamp(1'b0);
      test_random();
`ifdef PLAYER_JUMP_EN
      test_jump();
      model_step(1'b0, 1'b0);
`endif
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
